controle_varredura_servo: RTL and testbench
===========================================

Name: controle_varredura_servo

Overview:
- Sweep sequencer directly upstream of the servo PWM generator. Drives its 3-bit pulse-width select input.
- Steps the servo through positions 0..7..0 in a back-and-forth sweep.
- At each position: waits a settle time, pulses a measurement request, then waits for measurement-done or a timeout before stepping to the next position.
- Sits between the system top-level FSM (run enable) and the PWM and measurement blocks.

Parameters:
- T_ACOMODA, 25_000_000, settle time in clock cycles per position (500 ms at 50 MHz); must be ≥ 1.
- T_TIMEOUT, 50_000_000, maximum cycles spent waiting for medida_pronta (1 s at 50 MHz); must be ≥ 1.

Ports:
- clock  input  1  system clock, 50 MHz, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ligar  input  1  run enable; 1 = sweep runs, 0 = return to idle.
- medida_pronta  input  1  measurement-done pulse from the measurement block.
- posicao  output  3  position select; connects to the PWM block's largura input.
- sentido  output  1  sweep direction; 1 = increasing, 0 = decreasing.
- inicia_medida  output  1  one-cycle measurement start pulse.
- timeout  output  1  one-cycle pulse when a measurement wait expires.
- db_estado  output  3  current state code, for debug.

Behaviour:
- All outputs are registered. Moore decode from state: outputs are valid in the same cycle as the state they belong to. 32-bit internal timer.
- Reset (reset = 0, asynchronous):
  - state = INICIAL, timer = 0
  - posicao = 0, sentido = 1
  - inicia_medida = 0, timeout = 0
- State codes:
  - INICIAL = 000
  - ACOMODA = 001
  - MEDE = 010
  - AGUARDA = 011
  - PROXIMA = 100
  - Codes 101–111 are illegal and go to INICIAL on the next clock.
- INICIAL:
  - Hold posicao = 0, sentido = 1.
  - If ligar = 1, go to ACOMODA with timer = 0.
- ACOMODA:
  - Timer increments each cycle.
  - When timer == T_ACOMODA-1, go to MEDE.
  - Latency: ACOMODA is entered at cycle t; MEDE occurs at cycle t + T_ACOMODA.
- MEDE:
  - Lasts exactly one cycle; inicia_medida = 1 in this cycle only.
  - Timer is cleared; go to AGUARDA.
- AGUARDA:
  - Timer increments each cycle.
  - If medida_pronta = 1, go to PROXIMA.
  - Else if timer == T_TIMEOUT-1, go to PROXIMA and set timeout = 1 for that PROXIMA cycle.
  - If both conditions occur in the same cycle, medida_pronta wins and timeout stays 0.
- PROXIMA (one cycle), position update:
  - If sentido = 1 and posicao = 7: posicao = 6, sentido = 0.
  - Else if sentido = 0 and posicao = 0: posicao = 1, sentido = 1.
  - Else: posicao = posicao ± 1 according to sentido.
  - Then go to ACOMODA with timer = 0.
  - The new posicao is visible from the first ACOMODA cycle.
- Sweep order: 0,1,…,7,6,…,0,1,… with period 14 steps. Endpoints are visited once per pass, never repeated.
- ligar = 0 in any non-INICIAL state:
  - Next cycle goes to INICIAL with posicao = 0, sentido = 1, timer = 0, and no inicia_medida or timeout pulse.
  - This abort takes priority over every other transition.
- medida_pronta outside AGUARDA is ignored; no latching.
- posicao only changes in PROXIMA or on return to INICIAL. The PWM block samples it at its period boundary, so mid-period changes are harmless.

Test Plan (T_ACOMODA = 4, T_TIMEOUT = 10 unless noted):
- Reset check: reset = 0 mid-AGUARDA → outputs immediately posicao = 0, sentido = 1, inicia_medida = 0, timeout = 0, db_estado = 000, with no clock edge required.
- Settle latency: ligar rises, ACOMODA entered at cycle t → inicia_medida high only at cycle t+4, for one cycle; db_estado sequence 001,001,001,001,010,011.
- Handshake: medida_pronta pulsed 3 cycles into AGUARDA → PROXIMA next cycle, posicao 0→1, timeout stays 0.
- Timeout: medida_pronta held 0 → after 10 AGUARDA cycles, timeout = 1 for exactly one cycle and posicao advances. Separately, medida_pronta asserted in the same cycle the timer hits 9 → timeout stays 0.
- Full sweep: medida_pronta answered every time → posicao sequence 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1; sentido falls on 7→6 and rises on 0→1.
- Abort: ligar dropped at posicao = 5 during ACOMODA → next cycle db_estado = 000, posicao = 0, sentido = 1, and no inicia_medida pulse follows. Re-raising ligar restarts the sweep from 0.

Source files
------------

// File: rtl/controle_varredura_servo_if.sv
// Signal bundle between the sweep sequencer, the run-enable source and the PWM/measurement blocks.
interface controle_varredura_servo_if;
  logic       ligar;
  logic       medida_pronta;
  logic [2:0] posicao;
  logic       sentido;
  logic       inicia_medida;
  logic       timeout;
  logic [2:0] db_estado;

  modport master (
    output ligar, medida_pronta,
    input  posicao, sentido, inicia_medida, timeout, db_estado
  );

  modport slave (
    input  ligar, medida_pronta,
    output posicao, sentido, inicia_medida, timeout, db_estado
  );
endinterface

// File: rtl/controle_varredura_servo.sv
// Back-and-forth servo sweep sequencer: settle, request a measurement, wait for done or timeout, step.
//
// state   | meaning
// INICIAL | idle at position 0, waiting for ligar
// ACOMODA | servo settling at the current position
// MEDE    | one-cycle measurement request
// AGUARDA | waiting for medida_pronta or timeout
// PROXIMA | one-cycle step to the next sweep position
module controle_varredura_servo #(
  parameter int unsigned T_ACOMODA = 25_000_000,
  parameter int unsigned T_TIMEOUT = 50_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  controle_varredura_servo_if.slave     bus
);

  localparam logic [2:0] INICIAL = 3'b000;
  localparam logic [2:0] ACOMODA = 3'b001;
  localparam logic [2:0] MEDE    = 3'b010;
  localparam logic [2:0] AGUARDA = 3'b011;
  localparam logic [2:0] PROXIMA = 3'b100;

  localparam logic [31:0] ACOMODA_FIM = 32'(T_ACOMODA - 1);
  localparam logic [31:0] TIMEOUT_FIM = 32'(T_TIMEOUT - 1);

  logic [2:0]  estado, estado_prox;
  logic [31:0] timer, timer_prox;
  logic [2:0]  posicao, posicao_prox;
  logic        sentido, sentido_prox;
  logic        inicia, inicia_prox;
  logic        tmo, tmo_prox;

  always_comb begin
    estado_prox  = estado;
    timer_prox   = timer;
    posicao_prox = posicao;
    sentido_prox = sentido;
    tmo_prox     = 1'b0;

    // Dropping ligar aborts from anywhere, ahead of every other transition.
    if (estado != INICIAL && !bus.ligar) begin
      estado_prox  = INICIAL;
      timer_prox   = '0;
      posicao_prox = 3'd0;
      sentido_prox = 1'b1;
    end else begin
      case (estado)
        INICIAL: begin
          timer_prox   = '0;
          posicao_prox = 3'd0;
          sentido_prox = 1'b1;
          if (bus.ligar) estado_prox = ACOMODA;
        end
        ACOMODA: begin
          timer_prox = timer + 32'd1;
          if (timer == ACOMODA_FIM) estado_prox = MEDE;
        end
        MEDE: begin
          timer_prox  = '0;
          estado_prox = AGUARDA;
        end
        AGUARDA: begin
          timer_prox = timer + 32'd1;
          if (bus.medida_pronta) begin
            estado_prox = PROXIMA;
          end else if (timer == TIMEOUT_FIM) begin
            estado_prox = PROXIMA;
            tmo_prox    = 1'b1;
          end
        end
        PROXIMA: begin
          timer_prox  = '0;
          estado_prox = ACOMODA;
          // Endpoints reverse direction so each is visited once per pass.
          if (sentido && posicao == 3'd7) begin
            posicao_prox = 3'd6;
            sentido_prox = 1'b0;
          end else if (!sentido && posicao == 3'd0) begin
            posicao_prox = 3'd1;
            sentido_prox = 1'b1;
          end else if (sentido) begin
            posicao_prox = posicao + 3'd1;
          end else begin
            posicao_prox = posicao - 3'd1;
          end
        end
        default: begin
          estado_prox  = INICIAL;
          timer_prox   = '0;
          posicao_prox = 3'd0;
          sentido_prox = 1'b1;
        end
      endcase
    end

    inicia_prox = (estado_prox == MEDE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= INICIAL;
      timer   <= '0;
      posicao <= 3'd0;
      sentido <= 1'b1;
      inicia  <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      estado  <= estado_prox;
      timer   <= timer_prox;
      posicao <= posicao_prox;
      sentido <= sentido_prox;
      inicia  <= inicia_prox;
      tmo     <= tmo_prox;
    end
  end

  assign bus.posicao       = posicao;
  assign bus.sentido       = sentido;
  assign bus.inicia_medida = inicia;
  assign bus.timeout       = tmo;
  assign bus.db_estado     = estado;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Self-checking bench for the servo sweep sequencer, with a step-level sweep model.
module tb_controle_varredura_servo;

  logic clock;
  logic reset;
  int   checks;
  int   erros;
  int   k;

  controle_varredura_servo_if bus_if ();

  controle_varredura_servo #(
    .T_ACOMODA (4),
    .T_TIMEOUT (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [8:0] obs;
  assign obs = {bus_if.db_estado, bus_if.posicao, bus_if.sentido,
                bus_if.inicia_medida, bus_if.timeout};

  // Sweep position for step number n: 0..7 up, 6..1 down, period 14.
  function automatic logic [2:0] pos_de(input int n);
    int r;
    r = n % 14;
    return (r <= 7) ? 3'(r) : 3'(14 - r);
  endfunction

  // Direction is that of the last move; the first step starts upward.
  function automatic logic sent_de(input int n);
    if (n == 0) return 1'b1;
    return pos_de(n) > pos_de(n - 1);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Starts at the first ACOMODA cycle of step k; atraso = AGUARDA cycle that answers (>9 = none).
  task automatic run_passo(input int atraso, input bit ruido);
    logic [8:0] esp;
    logic [2:0] p;
    logic       s;
    bit         fim;
    p = pos_de(k);
    s = sent_de(k);
    for (int c = 0; c < 4; c++) begin
      esp = {3'd1, p, s, 2'b00};
      checks++;
      if (obs !== esp) begin
        erros++;
        $display("FAIL acomoda k=%0d c=%0d got=%b want=%b", k, c, obs, esp);
      end
      if (ruido) bus_if.medida_pronta = 1'($urandom_range(0, 1));
      tick;
    end
    esp = {3'd2, p, s, 2'b10};
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL mede k=%0d got=%b want=%b", k, obs, esp);
    end
    bus_if.medida_pronta = ruido ? 1'($urandom_range(0, 1)) : 1'b0;
    tick;
    bus_if.medida_pronta = 1'b0;
    for (int c = 0; c < 10; c++) begin
      esp = {3'd3, p, s, 2'b00};
      checks++;
      if (obs !== esp) begin
        erros++;
        $display("FAIL aguarda k=%0d c=%0d got=%b want=%b", k, c, obs, esp);
      end
      fim = (c == atraso) || (c == 9);
      if (c == atraso) bus_if.medida_pronta = 1'b1;
      tick;
      bus_if.medida_pronta = 1'b0;
      if (fim) break;
    end
    esp = {3'd4, p, s, 1'b0, (atraso > 9) ? 1'b1 : 1'b0};
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL proxima k=%0d got=%b want=%b", k, obs, esp);
    end
    tick;
    k++;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus_if.ligar = 1'b0;
    bus_if.medida_pronta = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs !== {3'd0, 3'd0, 1'b1, 2'b00}) begin
        erros++;
        $display("FAIL reset_idle c=%0d got=%b want=%b", c, obs, {3'd0, 3'd0, 1'b1, 2'b00});
      end
      bus_if.medida_pronta = 1'($urandom_range(0, 1));
      tick;
    end
    bus_if.medida_pronta = 1'b0;
  endtask

  task automatic test_latencia_handshake;
    bus_if.ligar = 1'b1;
    tick;
    k = 0;
    run_passo(3, 1'b0);
    checks++;
    if (bus_if.posicao !== 3'd1 || bus_if.timeout !== 1'b0) begin
      erros++;
      $display("FAIL handshake_pos got=%0d/%b want=1/0", bus_if.posicao, bus_if.timeout);
    end
  endtask

  task automatic test_timeout;
    run_passo(20, 1'b0);
    run_passo(9, 1'b0);
  endtask

  task automatic test_varredura;
    for (int i = 0; i < 16; i++)
      run_passo(int'($urandom_range(0, 12)), 1'b1);
  endtask

  task automatic test_abort;
    int guarda;
    guarda = 0;
    while (pos_de(k) != 3'd5 && guarda < 20) begin
      run_passo(int'($urandom_range(0, 9)), 1'b0);
      guarda++;
    end
    checks++;
    if (bus_if.posicao !== 3'd5) begin
      erros++;
      $display("FAIL abort_setup got=%0d want=5", bus_if.posicao);
    end
    tick;
    tick;
    bus_if.ligar = 1'b0;
    tick;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (obs !== {3'd0, 3'd0, 1'b1, 2'b00}) begin
        erros++;
        $display("FAIL abort c=%0d got=%b want=%b", c, obs, {3'd0, 3'd0, 1'b1, 2'b00});
      end
      tick;
    end
    bus_if.ligar = 1'b1;
    tick;
    k = 0;
    run_passo(int'($urandom_range(0, 9)), 1'b1);
    run_passo(int'($urandom_range(0, 9)), 1'b1);
  endtask

  task automatic test_reset_assincrono;
    for (int c = 0; c < 7; c++) tick;
    checks++;
    if (bus_if.db_estado !== 3'd3) begin
      erros++;
      $display("FAIL areset_setup got=%0d want=3", bus_if.db_estado);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== {3'd0, 3'd0, 1'b1, 2'b00}) begin
      erros++;
      $display("FAIL areset got=%b want=%b", obs, {3'd0, 3'd0, 1'b1, 2'b00});
    end
    bus_if.ligar = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    checks++;
    if (obs !== {3'd0, 3'd0, 1'b1, 2'b00}) begin
      erros++;
      $display("FAIL areset_release got=%b want=%b", obs, {3'd0, 3'd0, 1'b1, 2'b00});
    end
  endtask

  initial begin
    checks = 0;
    erros  = 0;
    k      = 0;
    test_reset;
    test_latencia_handshake;
    test_timeout;
    test_varredura;
    test_abort;
    test_reset_assincrono;
    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
